// File: rtl/sr_fun_unit_if.sv
// ---------------------------------------------------------------------------
// sr_fun_unit_if
// Operand/result bundle between the CPU function-control stage (master) and
// the sr_fun_unit arithmetic block (slave).
//   a_bi    [7:0]  operand a, unsigned (master -> slave)
//   b_bi    [7:0]  operand b, unsigned (master -> slave)
//   start_i        one-cycle start pulse (master -> slave)
//   busy_o         computation in progress (slave -> master)
//   y_bo    [24:0] last completed result a^3 + b^2 (slave -> master)
// ---------------------------------------------------------------------------
interface sr_fun_unit_if;
  logic [7:0]  a_bi;
  logic [7:0]  b_bi;
  logic        start_i;
  logic        busy_o;
  logic [24:0] y_bo;

  modport master (
    output a_bi, b_bi, start_i,
    input  busy_o, y_bo
  );

  modport slave (
    input  a_bi, b_bi, start_i,
    output busy_o, y_bo
  );
endinterface

// File: rtl/sr_fun_unit.sv
// ---------------------------------------------------------------------------
// sr_fun_unit
// Multi-cycle unit computing y = a^3 + b^2 for 8-bit unsigned operands.
// A single shift-add multiplier (one multiplier bit per cycle, LSB first)
// is reused for a*a, (a*a)*a and b*b, followed by one add cycle.
// Latency: busy for 25 cycles after the accepting edge; the result is
// written on the 26th edge, together with busy dropping.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-low reset
//   bus    sr_fun_unit_if.slave: a_bi, b_bi, start_i in; busy_o, y_bo out
// ---------------------------------------------------------------------------
module sr_fun_unit (
  input  logic          clk,
  input  logic          reset,
  sr_fun_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_A,
    S_CUBE_A,
    S_SQ_B,
    S_ADD
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_ra;
  logic [7:0]  r_rb;
  logic [23:0] r_mcand;   // multiplicand, shifted left each step
  logic [7:0]  r_mplier;  // multiplier, scanned bit by bit via r_cnt
  logic [23:0] r_acc;
  logic [2:0]  r_cnt;
  logic [23:0] r_cube;
  logic [24:0] r_y;
  logic        r_busy;

  logic        w_last;
  logic [23:0] w_acc_next;

  // The final bit of a phase is folded into the value handed to the next
  // phase, so each phase is exactly 8 cycles with no extra drain cycle.
  assign w_last     = (r_cnt == 3'd7);
  assign w_acc_next = r_acc + (r_mplier[r_cnt] ? r_mcand : 24'd0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first guarantees every path drives the
  // output, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start_i) w_state_next = S_SQ_A;
      S_SQ_A:   if (w_last)      w_state_next = S_CUBE_A;
      S_CUBE_A: if (w_last)      w_state_next = S_SQ_B;
      S_SQ_B:   if (w_last)      w_state_next = S_ADD;
      S_ADD:                     w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Datapath. A reset mid-computation clears everything, discarding the
  // partial result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ra     <= '0;
      r_rb     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_cube   <= '0;
      r_y      <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are captured only here; later input changes are ignored.
          if (bus.start_i) begin
            r_ra     <= bus.a_bi;
            r_rb     <= bus.b_bi;
            r_mcand  <= {16'd0, bus.a_bi};
            r_mplier <= bus.a_bi;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end

        S_SQ_A, S_CUBE_A, S_SQ_B: begin
          if (!w_last) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_cnt   <= r_cnt + 3'd1;
          end else begin
            r_cnt <= '0;
            if (r_state == S_SQ_A) begin
              // a^2 becomes the multiplicand for the cube phase.
              r_mcand  <= {8'd0, w_acc_next[15:0]};
              r_mplier <= r_ra;
              r_acc    <= '0;
            end else if (r_state == S_CUBE_A) begin
              r_cube   <= w_acc_next;
              r_mcand  <= {16'd0, r_rb};
              r_mplier <= r_rb;
              r_acc    <= '0;
            end else begin
              // b^2 stays in the accumulator for the add cycle.
              r_acc <= w_acc_next;
            end
          end
        end

        S_ADD: begin
          r_y    <= {1'b0, r_cube} + {1'b0, r_acc};
          r_busy <= 1'b0;
        end

        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.busy_o = r_busy;
  assign bus.y_bo   = r_y;

endmodule

// File: tb/tb_sr_fun_unit.sv
// ---------------------------------------------------------------------------
// tb_sr_fun_unit
// Self-checking bench for sr_fun_unit: a table of fixed vectors, hand-made
// sequences for back-to-back, ignored starts and mid-operation reset, then
// random operands compared against a plain a*a*a + b*b reference.
// ---------------------------------------------------------------------------
module tb_sr_fun_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  sr_fun_unit_if bus ();

  sr_fun_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [24:0] y;
  } vec_t;

  function automatic logic [24:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    return 25'(ai * ai * ai + bi * bi);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start (must be called one step after an edge, in IDLE), then
  // follows busy until it drops. With disturb set, operands are scrambled
  // every busy cycle and a second start pulse is attempted mid-operation.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [24:0] exp, input bit disturb, input string name);
    logic [24:0] y_hold;
    int          n;
    bit          stable;
    bus.a_bi    = a;
    bus.b_bi    = b;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    y_hold = bus.y_bo;
    n      = 0;
    stable = 1'b1;
    while (bus.busy_o && n < 100) begin
      n++;
      if (bus.y_bo !== y_hold) stable = 1'b0;
      if (disturb) begin
        bus.a_bi    = 8'($urandom);
        bus.b_bi    = 8'($urandom);
        bus.start_i = (n == 5);
      end
      tick();
    end
    bus.start_i = 1'b0;
    check({name, " busy_len"}, n, 25);
    check({name, " y"}, bus.y_bo, exp);
    check({name, " y_stable"}, stable, 1);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [24:0] y_hold;
    int          n;
    bit          stable;

    errors      = 0;
    checks      = 0;
    reset       = 1'b0;
    bus.a_bi    = '0;
    bus.b_bi    = '0;
    bus.start_i = 1'b0;

    vecs[0] = '{8'd0,   8'd0,   25'd0};
    vecs[1] = '{8'd2,   8'd3,   25'd17};
    vecs[2] = '{8'd255, 8'd255, 25'd16646400};
    vecs[3] = '{8'd10,  8'd7,   25'd1049};
    vecs[4] = '{8'd1,   8'd0,   25'd1};
    vecs[5] = '{8'd3,   8'd4,   25'd43};
    vecs[6] = '{8'd0,   8'd255, 25'd65025};
    vecs[7] = '{8'd255, 8'd0,   25'd16581375};

    // Reset state.
    tick();
    tick();
    check("reset busy", bus.busy_o, 0);
    check("reset y", bus.y_bo, 0);
    reset = 1'b1;
    tick();

    // Table vectors, issued back-to-back at the earliest allowed edge.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].y, 1'b0, $sformatf("vec%0d", i));
    end
    check("max y bit24", 32'(bus.y_bo[24]), 0);

    // A start sampled on the ADD edge is ignored.
    tick();
    bus.a_bi    = 8'd2;
    bus.b_bi    = 8'd3;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n = 1;
    while (n < 25 && bus.busy_o) begin
      n++;
      tick();
    end
    check("e25 reached", n, 25);
    bus.a_bi    = 8'd5;
    bus.b_bi    = 8'd5;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("e25 done busy", bus.busy_o, 0);
    check("e25 y", bus.y_bo, 17);
    tick();
    check("e25 start ignored", bus.busy_o, 0);

    // Start pulse and toggling operands mid-operation.
    run_op(8'd1, 8'd0, 25'd1, 1'b1, "disturb");
    tick();
    tick();
    check("disturb no 2nd op", bus.busy_o, 0);
    check("disturb y held", bus.y_bo, 1);

    // Reset in the middle of an operation.
    bus.a_bi    = 8'd200;
    bus.b_bi    = 8'd100;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("pre-reset busy", bus.busy_o, 1);
    reset = 1'b0;
    tick();
    check("mid reset busy", bus.busy_o, 0);
    check("mid reset y", bus.y_bo, 0);
    reset = 1'b1;
    tick();
    run_op(8'd3, 8'd4, 25'd43, 1'b0, "after reset");

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      run_op(ra, rb, ref_y(ra, rb), 1'b0, $sformatf("rand%0d a=%0d b=%0d", i, ra, rb));
    end

    // y must hold in idle.
    y_hold = bus.y_bo;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.y_bo !== y_hold) stable = 1'b0;
    end
    check("idle y hold", stable, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
